fault_sched: RTL
================

# fault_sched

Campaign controller that sits directly upstream of the `lfsr` pseudo-random stage and directly downstream of it in the data sense:
- drives the LFSR's seed-load and shift-enable controls;
- samples its output to build one fault per step: a target address plus a one-hot bit-flip mask;
- issues each fault over a valid/ready handshake to the injection target.

It injects a programmed number of faults, spaced by a programmable idle interval.

## Interface
- `N_bits`, 8, address width; equals the LFSR width.
- `DATA_W`, 32, target word width; power of two, ≥2. `IDX_W = $clog2(DATA_W)`, must be ≤ `N_bits`.
- `CNT_W`, 16, width of the count and interval fields.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cfg_start`  in  1  start pulse; sampled only in IDLE.
- `cfg_abort`  in  1  abort campaign.
- `cfg_seed`  in  N_bits  LFSR seed.
- `cfg_num_faults`  in  CNT_W  faults to issue.
- `cfg_interval`  in  CNT_W  idle cycles between a handshake and the next ADV_A.
- `lfsr_start`  out  1  to LFSR seed-load.
- `lfsr_en`  out  1  to LFSR shift-enable.
- `lfsr_seed`  out  N_bits  to LFSR seed input.
- `lfsr_value`  in  N_bits  LFSR register output.
- `flt_valid`  out  1  fault offered.
- `flt_ready`  in  1  target accepts.
- `flt_addr`  out  N_bits  fault address.
- `flt_mask`  out  DATA_W  one-hot bit-flip mask.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `faults_issued`  out  CNT_W  handshakes completed in the current or last campaign.

## Operation
- States: IDLE, SEED, ADV_A, CAP_A, CAP_B, ISSUE, GAP, DONE.
- IDLE + `cfg_start`:
  - latch seed, count and interval; clear `faults_issued`.
  - If the latched count is 0, go to DONE.
  - Otherwise go to SEED.
- SEED:
  - `lfsr_start`=1; `lfsr_seed` = latched seed, or 1 if the seed is 0 (an all-zero LFSR locks up).
  - Next state: ADV_A.
- ADV_A: `lfsr_en`=1. Next state: CAP_A.
- CAP_A: `flt_addr` ← `lfsr_value`; `lfsr_en`=1. Next state: CAP_B.
- CAP_B: bit index ← `lfsr_value[IDX_W-1:0]`; `flt_mask` ← 1 << index. Next state: ISSUE.
- ISSUE:
  - `flt_valid`=1; `flt_addr` and `flt_mask` are held stable until `flt_ready`.
  - On handshake, `faults_issued` increments.
  - If the new count equals the latched count, go to DONE.
  - Otherwise, if interval = 0, go to ADV_A.
  - Otherwise load the gap counter with the interval and go to GAP.
- GAP: the counter decrements each cycle; on the cycle the counter is 1, go to ADV_A.
- DONE: `done`=1 for one cycle. Next state: IDLE.
- `lfsr_start` and `lfsr_en` are never high together, and are 0 outside the states listed above.
- `cfg_abort`:
  - In any non-IDLE state, go to IDLE next cycle with no `done` pulse; `flt_valid` drops immediately after that edge.
  - Abort in the same cycle as a handshake: the handshake counts, then go to IDLE.
  - Abort has priority over `cfg_start`.
- `cfg_start` while busy: ignored. `cfg_*` changes mid-campaign: no effect.
- `faults_issued` holds its value in IDLE until the next start.

## Timing
- Reset values:
  - state IDLE;
  - `lfsr_start`, `lfsr_en`, `flt_valid`, `busy`, `done` = 0;
  - `flt_addr`, `flt_mask`, `faults_issued`, `lfsr_seed` = 0.
- Reset mid-campaign behaves as reset from any state, including mid-ISSUE; there is no `done`.
- The LFSR loads or shifts on the edge ending the cycle in which its control is high. `lfsr_value` is valid the following cycle.
- Start sampled at edge 0: SEED in cycle 1, ADV_A cycle 2, CAP_A cycle 3, CAP_B cycle 4, first `flt_valid` cycle 5.
- With `flt_ready` held high, one fault takes interval+4 cycles from one `flt_valid` to the next.
- A campaign of N faults takes 4N + (N−1)·interval cycles of busy plus SEED and DONE, when `flt_ready` is high throughout.
- `done` is asserted in the cycle after the last handshake. `busy` falls in the cycle after `done`.

## Test plan
- Scripted LFSR stub: it loads seed 0x5A, then shifts 0x5A→0x2D→0x23→0x91. cfg seed=0x5A, num=1, interval=0, `flt_ready`=1, start at edge 0.
  - Required: `flt_valid` in cycle 5 with `flt_addr`=0x2D, `flt_mask`=0x00000008.
  - Then `done` in cycle 6, `faults_issued`=1.
- num=3, interval=2, ready high, real `lfsr` attached: exactly 3 handshakes, 6 cycles apart; `done` once; `faults_issued`=3.
- Backpressure: ready low for 4 cycles during ISSUE: `flt_valid`, `flt_addr` and `flt_mask` stay stable for those 4 cycles; the count increments only on the ready cycle.
- Seed 0: `lfsr_seed`=0x01 in SEED. num=0: `done` in cycle 1; `lfsr_start`/`lfsr_en` never high; `faults_issued`=0.
- `cfg_abort` in GAP after 1 of 4 faults: IDLE next cycle, no `done`, `faults_issued`=1. `cfg_start` issued while busy: ignored.
- Reset asserted during ISSUE: all outputs take their reset values on the next cycle.

Source files
------------

// File: rtl/fault_sched.sv
// Fault-injection campaign controller: seeds and steps an external LFSR, turns its output
// into (address, one-hot bit-flip mask) faults and offers them to a target over valid/ready.
module fault_sched #(
    parameter int N_bits = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [N_bits-1:0] cfg_seed,
    input  logic [CNT_W-1:0]  cfg_num_faults,
    input  logic [CNT_W-1:0]  cfg_interval,
    output logic              lfsr_start,
    output logic              lfsr_en,
    output logic [N_bits-1:0] lfsr_seed,
    input  logic [N_bits-1:0] lfsr_value,
    output logic              flt_valid,
    input  logic              flt_ready,
    output logic [N_bits-1:0] flt_addr,
    output logic [DATA_W-1:0] flt_mask,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  faults_issued
);

    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_ADV_A,
        S_CAP_A,
        S_CAP_B,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_bits-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  ivl_q, ivl_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_bits-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mask_q, mask_d;

    logic              start_ok;
    logic              handshake;
    logic [CNT_W-1:0]  cnt_inc;

    // Valid/ready: a fault is transferred in any cycle where flt_valid and flt_ready are
    // both high; while flt_valid is high without ready, flt_addr/flt_mask do not change.
    assign start_ok  = (state_q == S_IDLE) && cfg_start && !cfg_abort;
    assign handshake = (state_q == S_ISSUE) && flt_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            seed_q  <= '0;
            num_q   <= '0;
            ivl_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            num_q   <= num_d;
            ivl_q   <= ivl_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (cfg_num_faults == '0) ? S_DONE : S_SEED;
                end
            end
            S_SEED:  state_d = S_ADV_A;
            S_ADV_A: state_d = S_CAP_A;
            S_CAP_A: state_d = S_CAP_B;
            S_CAP_B: state_d = S_ISSUE;
            S_ISSUE: begin
                if (flt_ready) begin
                    if (cnt_inc == num_q) begin
                        state_d = S_DONE;
                    end else if (ivl_q == '0) begin
                        state_d = S_ADV_A;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == CNT_W'(1)) begin
                    state_d = S_ADV_A;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, but a handshake in the same cycle still counts.
        if (cfg_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        seed_d = seed_q;
        num_d  = num_q;
        ivl_d  = ivl_q;
        gap_d  = gap_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        mask_d = mask_q;
        if (start_ok) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            seed_d = (cfg_seed == '0) ? N_bits'(1) : cfg_seed;
            num_d  = cfg_num_faults;
            ivl_d  = cfg_interval;
            cnt_d  = '0;
        end
        if (state_q == S_CAP_A) begin
            addr_d = lfsr_value;
        end
        if (state_q == S_CAP_B) begin
            mask_d = DATA_W'(1) << lfsr_value[IDX_W-1:0];
        end
        if (handshake) begin
            cnt_d = cnt_inc;
            gap_d = ivl_q;
        end
        if (state_q == S_GAP) begin
            gap_d = gap_q - CNT_W'(1);
        end
    end

    always_comb begin
        lfsr_start    = (state_q == S_SEED);
        lfsr_en       = (state_q == S_ADV_A) || (state_q == S_CAP_A);
        flt_valid     = (state_q == S_ISSUE);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        lfsr_seed     = seed_q;
        flt_addr      = addr_q;
        flt_mask      = mask_q;
        faults_issued = cnt_q;
    end

endmodule
